// File: rtl/cabin_light_pkg.sv
// Shared definitions for the cabin lighting controller: zone modes and
// the mode-to-brightness mapping.
package cabin_light_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE      = 2'b00,
        MODE_NORMAL    = 2'b01,
        MODE_DIMMING   = 2'b10,
        MODE_EMERGENCY = 2'b11
    } mode_e;

    // EMERGENCY has no target of its own; the level is frozen there.
    function automatic int unsigned mode_target(mode_e m, int unsigned pwm_w,
                                                int unsigned dim_level);
        case (m)
            MODE_NORMAL:  return (32'd1 << pwm_w) - 32'd1;
            MODE_DIMMING: return dim_level;
            default:      return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/cabin_light_zone.sv
// One lighting zone: requested-mode register, brightness ramp and
// registered LED drive (PWM compare or emergency blink).
module cabin_light_zone #(
    parameter int unsigned PWM_W     = 8,
    parameter int unsigned DIM_LEVEL = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic [PWM_W-1:0] pwm_cnt_i,
    input  logic             blink_i,
    input  logic             emerg_i,
    input  logic [1:0]       mode_sel_i,
    input  logic             mode_valid_i,
    output logic             led_o,
    output logic [1:0]       state_o,
    output logic [PWM_W-1:0] level_o,
    output logic             busy_o
);
    import cabin_light_pkg::*;

    mode_e            req_q, req_d;
    mode_e            state_q, state_d;
    logic [PWM_W-1:0] level_q, level_d;
    logic             led_q, led_d;
    mode_e            eff;
    logic [PWM_W-1:0] target;
    logic             frozen;

    // The override is applied combinationally so the ramp freezes on the
    // same edge emerg_all is first seen; zone_state is the registered copy.
    always_comb begin
        eff    = emerg_i ? MODE_EMERGENCY : req_q;
        frozen = (eff == MODE_EMERGENCY);
        target = PWM_W'(mode_target(eff, PWM_W, DIM_LEVEL));
    end

    always_comb begin
        req_d   = mode_valid_i ? mode_e'(mode_sel_i) : req_q;
        state_d = eff;
        level_d = level_q;
        if (tick_i && !frozen) begin
            if (level_q < target) begin
                level_d = level_q + 1'b1;
            end else if (level_q > target) begin
                level_d = level_q - 1'b1;
            end
        end
        if (frozen) begin
            led_d = blink_i;
        end else if (level_q == '1) begin
            led_d = 1'b1;
        end else begin
            led_d = (pwm_cnt_i < level_q);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_q   <= MODE_IDLE;
            state_q <= MODE_IDLE;
            level_q <= '0;
            led_q   <= 1'b0;
        end else begin
            req_q   <= req_d;
            state_q <= state_d;
            level_q <= level_d;
            led_q   <= led_d;
        end
    end

    assign led_o   = led_q;
    assign state_o = state_q;
    assign level_o = level_q;
    assign busy_o  = !frozen && (level_q != target);

endmodule

// File: rtl/cabin_light_ctrl.sv
// Multi-zone cabin lighting controller: shared ramp prescaler, PWM and
// blink counters driving NUM_ZONES independent zone instances.
module cabin_light_ctrl #(
    parameter int unsigned NUM_ZONES = 4,
    parameter int unsigned PWM_W     = 8,
    parameter int unsigned RAMP_DIV  = 16,
    parameter int unsigned DIM_LEVEL = 64,
    parameter int unsigned BLINK_W   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2*NUM_ZONES-1:0]     mode_sel,
    input  logic [NUM_ZONES-1:0]       mode_valid,
    input  logic                       emerg_all,
    output logic [NUM_ZONES-1:0]       led,
    output logic [2*NUM_ZONES-1:0]     zone_state,
    output logic [PWM_W*NUM_ZONES-1:0] level,
    output logic [NUM_ZONES-1:0]       busy
);
    import cabin_light_pkg::*;

    localparam int unsigned PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [PWM_W-1:0]   pwm_q, pwm_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic               tick;

    always_comb begin
        tick    = (pre_q == PRE_W'(RAMP_DIV - 1));
        pre_d   = tick ? '0 : pre_q + 1'b1;
        pwm_d   = pwm_q + 1'b1;
        blink_d = blink_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q   <= '0;
            pwm_q   <= '0;
            blink_q <= '0;
        end else begin
            pre_q   <= pre_d;
            pwm_q   <= pwm_d;
            blink_q <= blink_d;
        end
    end

    for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
        cabin_light_zone #(
            .PWM_W    (PWM_W),
            .DIM_LEVEL(DIM_LEVEL)
        ) u_zone (
            .clk_i       (clk),
            .rst_i       (reset),
            .tick_i      (tick),
            .pwm_cnt_i   (pwm_q),
            .blink_i     (blink_q[BLINK_W-1]),
            .emerg_i     (emerg_all),
            .mode_sel_i  (mode_sel[2*z +: 2]),
            .mode_valid_i(mode_valid[z]),
            .led_o       (led[z]),
            .state_o     (zone_state[2*z +: 2]),
            .level_o     (level[PWM_W*z +: PWM_W]),
            .busy_o      (busy[z])
        );
    end

endmodule

// File: doc/cabin_light_ctrl.md
CABIN_LIGHT_CTRL -- requirements
Module: cabin_light_ctrl

Interface
REQ-001 SHALL have parameter NUM_ZONES, default 4, number of independent lighting zones (1..16).
REQ-002 SHALL have parameter PWM_W, default 8, brightness/PWM width in bits (4..12).
REQ-003 SHALL have parameter RAMP_DIV, default 16, clocks per one-step brightness change (>=1).
REQ-004 SHALL have parameter DIM_LEVEL, default 64, DIMMING target brightness (< 2^PWM_W).
REQ-005 SHALL have parameter BLINK_W, default 4, emergency blink counter width; the blink period is 2^BLINK_W clocks.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 mode_sel  input  2*NUM_ZONES  requested mode per zone; zone z uses bits [2z+1:2z]; 00 IDLE, 01 NORMAL, 10 DIMMING, 11 EMERGENCY.
REQ-009 mode_valid  input  NUM_ZONES  per-zone load strobe for mode_sel.
REQ-010 emerg_all  input  1  global emergency override, level-sensitive.
REQ-011 led  output  NUM_ZONES  PWM/blink drive per zone.
REQ-012 zone_state  output  2*NUM_ZONES  effective mode per zone, same encoding as mode_sel.
REQ-013 level  output  PWM_W*NUM_ZONES  current brightness per zone.
REQ-014 busy  output  NUM_ZONES  high while the zone is ramping (level != target, not in EMERGENCY).

Function
REQ-015 Each zone SHALL latch mode_sel into a requested-mode register on a clk edge where its mode_valid bit is 1; the mode is unchanged otherwise.
REQ-016 Effective mode SHALL be EMERGENCY while emerg_all=1; otherwise it equals the requested mode; zone_state SHALL be registered and reflect the mode one cycle after the latching edge.
REQ-017 Target brightness SHALL be: IDLE 0, NORMAL 2^PWM_W-1, DIMMING DIM_LEVEL.
REQ-018 A shared prescaler SHALL count 0..RAMP_DIV-1 and assert a one-cycle tick at RAMP_DIV-1; on each tick, every non-EMERGENCY zone's level SHALL move one step toward its target.
REQ-019 Level SHALL saturate at its target without overshoot and SHALL never wrap below 0 or above 2^PWM_W-1.
REQ-020 A mode change mid-ramp SHALL retarget immediately; the ramp continues from the present level.
REQ-021 A shared free-running PWM counter (PWM_W bits) SHALL wrap from 2^PWM_W-1 to 0; led SHALL be registered as 1 when level = 2^PWM_W-1, else (pwm_cnt < level).
REQ-022 In EMERGENCY, the level SHALL freeze, led SHALL equal the MSB of a shared free-running BLINK_W counter, and busy SHALL be 0.
REQ-023 On EMERGENCY exit, the zone SHALL resume ramping from its frozen level toward the requested mode's target.
REQ-024 A mode_valid strobe and an emerg_all change on the same edge SHALL both take effect; the requested mode is stored even while overridden.

Reset
REQ-025 reset SHALL asynchronously clear: requested modes to IDLE, zone_state 0, level 0, led 0, busy 0, prescaler, PWM and blink counters 0.
REQ-026 Reset asserted mid-ramp or mid-emergency SHALL abandon all activity; the first tick after release occurs RAMP_DIV clocks later.

Structure
REQ-027 Package cabin_light_pkg SHALL hold the 2-bit mode enum (IDLE, NORMAL, DIMMING, EMERGENCY) and a function mapping mode to target level.
REQ-028 Per-zone logic (mode register, level ramp, led compare) SHALL be sub-module cabin_light_zone, instantiated NUM_ZONES times via generate; the prescaler, PWM and blink counters are shared in the top.

Verification (PWM_W=4, RAMP_DIV=2, DIM_LEVEL=6, BLINK_W=3, NUM_ZONES=2)
REQ-029 Reset release, zone0 NORMAL strobe -> zone_state0=01 next cycle; level0 counts 0..15 in 15 ticks (30 clocks); busy0 drops when level0=15; led0 held 1.
REQ-030 Zone0 at 15, request DIMMING -> level0 decrements to 6 and holds; led0 high 6 of every 16 clocks.
REQ-031 Zone1 ramping at 3 toward 15, emerg_all=1 for 20 clocks -> zone_state=11 for both zones, level1 frozen at 3, led toggles every 4 clocks; on release, level1 resumes 4,5,...
REQ-032 Mode_valid on zone1 to IDLE in the same cycle emerg_all rises -> EMERGENCY shown; after release, zone1 ramps down to 0.
REQ-033 Reset asserted at level0=9 -> all outputs 0 immediately, without waiting for clk.
REQ-034 NORMAL then IDLE requested at level 2 -> level 1, 0, holds at 0, never wraps to 15.
